// File: rtl/insn_queue.sv
// insn_queue -- instruction queue between fetch and decode.
//
// Holds up to DEPTH {pc, insn} pairs in a circular buffer. Each side uses a
// valid/ready handshake. A flush empties the queue on a branch or jump
// redirect.
//
// Handshake rule: a transfer happens on a rising clock edge when valid and
// ready are both 1 in the cycle before that edge. enq_ready_o never depends
// on deq_ready_i, so a full queue refuses an enqueue even when a dequeue
// happens in the same cycle.
//
// Optional feature: define INSN_QUEUE_BYPASS_EN to enable the empty-queue
// bypass. With the bypass, an enqueue into an empty queue is also presented
// on the dequeue side in the same cycle. Without it (the default), the
// minimum enqueue-to-dequeue latency is one cycle.
//
// Ports:
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous reset, active low
//   flush_i      discard all entries at the next edge
//   enq_valid_i  fetch presents {enq_pc_i, enq_insn_i}
//   enq_ready_o  queue can accept this cycle
//   enq_pc_i     PC of the instruction being enqueued
//   enq_insn_i   instruction word being enqueued
//   deq_valid_o  head entry is valid
//   deq_ready_i  decode consumes the head this cycle
//   deq_pc_o     head PC (show-ahead)
//   deq_insn_o   head instruction (show-ahead)
//   count_o      number of occupied entries, 0..DEPTH
module insn_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [AWIDTH-1:0]        enq_pc_i,
  input  logic [DWIDTH-1:0]        enq_insn_i,
  output logic                     deq_valid_o,
  input  logic                     deq_ready_i,
  output logic [AWIDTH-1:0]        deq_pc_o,
  output logic [DWIDTH-1:0]        deq_insn_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AWIDTH-1:0] pc_mem   [DEPTH];
  logic [DWIDTH-1:0] insn_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic bypass;      // empty-queue pass-through is active this cycle
  logic enq_fire;
  logic deq_fire;
  logic mem_write;   // the enqueued entry actually lands in storage
  logic mem_read;    // the head leaves storage (not the bypassed entry)

  assign enq_ready_o = rst && (count != FULL_COUNT);

`ifdef INSN_QUEUE_BYPASS_EN
  // Gating with rst keeps the outputs at 0 during reset even if fetch is
  // already presenting valid data.
  assign bypass = rst && (count == '0) && enq_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid_o = ((count != '0) || bypass) && !flush_i;
  assign deq_pc_o    = bypass ? enq_pc_i   : pc_mem[rd_ptr];
  assign deq_insn_o  = bypass ? enq_insn_i : insn_mem[rd_ptr];
  assign count_o     = count;

  assign enq_fire  = enq_valid_i && enq_ready_o;
  assign deq_fire  = deq_valid_o && deq_ready_i;
  // A bypassed entry that decode takes at once never touches storage.
  assign mem_write = enq_fire && !(bypass && deq_ready_i);
  assign mem_read  = deq_fire && !bypass;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      // Storage is left as is; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (mem_write) wr_ptr <= wr_ptr + PW'(1);
      if (mem_read)  rd_ptr <= rd_ptr + PW'(1);
      if (mem_write && !mem_read)      count <= count + CW'(1);
      else if (mem_read && !mem_write) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        insn_mem[i] <= '0;
      end
    end else if (mem_write && !flush_i) begin
      pc_mem[wr_ptr]   <= enq_pc_i;
      insn_mem[wr_ptr] <= enq_insn_i;
    end
  end

endmodule

// File: tb/tb_insn_queue.sv
// Testbench for insn_queue: directed scenarios followed by random traffic.
// A reference queue of expected {pc, insn} pairs is updated as transfers
// are issued, and a monitor on the falling edge compares the DUT outputs.
module tb_insn_queue;

  localparam int DWIDTH = 32;
  localparam int AWIDTH = 32;
  localparam int DEPTH  = 4;
  localparam int EW     = AWIDTH + DWIDTH;

  logic              clk;
  logic              rst;
  logic              flush_i;
  logic              enq_valid_i;
  logic              enq_ready_o;
  logic [AWIDTH-1:0] enq_pc_i;
  logic [DWIDTH-1:0] enq_insn_i;
  logic              deq_valid_o;
  logic              deq_ready_i;
  logic [AWIDTH-1:0] deq_pc_o;
  logic [DWIDTH-1:0] deq_insn_o;
  logic [$clog2(DEPTH):0] count_o;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  insn_queue #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .enq_valid_i(enq_valid_i),
    .enq_ready_o(enq_ready_o),
    .enq_pc_i(enq_pc_i),
    .enq_insn_i(enq_insn_i),
    .deq_valid_o(deq_valid_o),
    .deq_ready_i(deq_ready_i),
    .deq_pc_o(deq_pc_o),
    .deq_insn_o(deq_insn_o),
    .count_o(count_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and reference model: outputs are compared at the falling edge,
  // then the model applies what the coming rising edge will do.
  always @(negedge clk) begin
    int sz;
    logic byp;
    logic exp_rdy;
    logic exp_dv;
    logic [EW-1:0] head;
    if (!rst) begin
      chk("reset_enq_ready", 64'(enq_ready_o), 64'(0));
      chk("reset_deq_valid", 64'(deq_valid_o), 64'(0));
      chk("reset_count",     64'(count_o),     64'(0));
      chk("reset_deq_pc",    64'(deq_pc_o),    64'(0));
      chk("reset_deq_insn",  64'(deq_insn_o),  64'(0));
      exp_q.delete();
    end else begin
      sz  = exp_q.size();
      byp = 1'b0;
`ifdef INSN_QUEUE_BYPASS_EN
      byp = (sz == 0) && enq_valid_i && !flush_i;
`endif
      exp_rdy = (sz < DEPTH);
      exp_dv  = ((sz > 0) || byp) && !flush_i;
      chk("enq_ready", 64'(enq_ready_o), 64'(exp_rdy));
      chk("deq_valid", 64'(deq_valid_o), 64'(exp_dv));
      chk("count",     64'(count_o),     64'(sz));
      if (exp_dv && deq_ready_i) begin
        head = byp ? {enq_pc_i, enq_insn_i} : exp_q[0];
        chk("deq_pc",   64'(deq_pc_o),   64'(head[EW-1:DWIDTH]));
        chk("deq_insn", 64'(deq_insn_o), 64'(head[DWIDTH-1:0]));
      end
      if (flush_i) begin
        exp_q.delete();
      end else if (byp) begin
        if (!deq_ready_i) exp_q.push_back({enq_pc_i, enq_insn_i});
      end else begin
        if (exp_dv && deq_ready_i) void'(exp_q.pop_front());
        if (enq_valid_i && exp_rdy) exp_q.push_back({enq_pc_i, enq_insn_i});
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge and hold for
  // one full cycle.
  task automatic cycle(input logic ev, input logic [AWIDTH-1:0] pc,
                       input logic [DWIDTH-1:0] insn, input logic dr,
                       input logic fl);
    enq_valid_i = ev;
    enq_pc_i    = pc;
    enq_insn_i  = insn;
    deq_ready_i = dr;
    flush_i     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    flush_i = 1'b0;
    enq_valid_i = 1'b1;
    enq_pc_i = 32'h0100_0000;
    enq_insn_i = 32'h0000_0013;
    deq_ready_i = 1'b0;

    // Reset held for 3 cycles with fetch presenting data.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0100_0000, 32'h0000_0013, 1'b0, 1'b0);
    rst = 1'b1;

    // Fill to DEPTH, then attempt a fifth enqueue, then drain in order.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0100_0000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h0100_0010, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 32'h0100_0000 + 32'(4 * i), $urandom, 1'b1, 1'b0);
    idle(2);

    // Full with simultaneous dequeue: one leaves, none enters.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h0100_0020 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h0100_0030, $urandom, 1'b1, 1'b0);
    cycle(1'b1, 32'h0100_0034, $urandom, 1'b0, 1'b0);
    idle(5);

    // Flush with activity at count 3, then a fresh entry is next out.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h0100_0000 + 32'(4 * i), $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h0100_0038, $urandom, 1'b1, 1'b1);
    cycle(1'b1, 32'h0100_0040, $urandom, 1'b0, 1'b0);
    idle(2);

    // Empty-queue enqueue with decode ready (bypass case when enabled).
    cycle(1'b1, 32'h0100_0044, 32'h0000_0013, 1'b1, 1'b0);
    idle(2);

    // Random traffic with occasional flushes and asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        enq_valid_i = 1'b1;
        deq_ready_i = $urandom_range(0, 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      end
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
